// File: rtl/core_sync_pkg.sv
// Shared definitions for the core-end synchroniser and the per-core run controllers.
// Holds the run/halt command encodings, the run-controller state encoding,
// the default PC width, and a state-to-enable decode helper.
package core_sync_pkg;

  localparam int PC_W_DEF = 16;

  // 2-bit command broadcast from the synchroniser to each core
  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  // Datapath is enabled in every state where an instruction may be in flight
  function automatic logic state_core_en(state_e s);
    return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/core_run_ctrl.sv
// Per-core run/halt controller.
// Decodes the 2-bit end_core command, drains any in-flight instruction before
// halting, gates the datapath via core_en and owns the core's PC register.
//
// Ports:
//   clock       system clock (rising edge)
//   reset_n     asynchronous active-low reset
//   end_core    command: 00 RUN, 01 STEP, 10 HALT, 11 reserved (hold)
//   instr_busy  core is mid-instruction
//   pc_we       core requests a PC update
//   pc_next     next PC value from the core
//   core_en     registered datapath enable
//   pc_out      registered PC
//   halted      registered, high only in HALTED
//   halt_cnt    saturating halted-cycle count (only with CORE_HALT_CNT_EN)
//
// Optional feature macro: CORE_HALT_CNT_EN adds the halt_cnt port and counter.
module core_run_ctrl
  import core_sync_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       end_core,
  input  logic             instr_busy,
  input  logic             pc_we,
  input  logic [PC_W-1:0]  pc_next,
  output logic             core_en,
  output logic [PC_W-1:0]  pc_out,
`ifdef CORE_HALT_CNT_EN
  output logic [CNT_W-1:0] halt_cnt,
`endif
  output logic             halted
);

  state_e          state_q, state_d;
  logic            core_en_q, core_en_d;
  logic            halted_q, halted_d;
  logic            step_seen_q, step_seen_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (end_core == CMD_RUN)       state_d = ST_RUN;
        else if (end_core == CMD_STEP) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (end_core == CMD_HALT)      state_d = instr_busy ? ST_DRAIN : ST_HALTED;
        else if (end_core == CMD_STEP) state_d = ST_STEP;
      end
      // Commands are ignored here: the in-flight instruction always completes
      ST_DRAIN: begin
        if (!instr_busy) state_d = ST_HALTED;
      end
      // Leave only after a full busy pulse; with no issue yet, keep waiting
      ST_STEP: begin
        if (step_seen_q && !instr_busy) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (end_core == CMD_RUN)       state_d = ST_RUN;
        else if (end_core == CMD_STEP) state_d = ST_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tracks whether the stepped instruction has gone busy; zero on STEP entry
  assign step_seen_d = (state_q == ST_STEP) ? (step_seen_q | instr_busy) : 1'b0;

  // Outputs are decoded from the next state so they change with the state flop
  assign core_en_d = state_core_en(state_d);
  assign halted_d  = (state_d == ST_HALTED);

  // instr_busy keeps the write path open on the last busy cycle of a drain/step
  assign pc_d = (pc_we && (core_en_q || instr_busy)) ? pc_next : pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      core_en_q   <= 1'b0;
      halted_q    <= 1'b0;
      step_seen_q <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      state_q     <= state_d;
      core_en_q   <= core_en_d;
      halted_q    <= halted_d;
      step_seen_q <= step_seen_d;
      pc_q        <= pc_d;
    end
  end

  assign core_en = core_en_q;
  assign halted  = halted_q;
  assign pc_out  = pc_q;

`ifdef CORE_HALT_CNT_EN
  logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;

  // Clear on leaving HALTED takes priority; otherwise saturate at all-ones
  always_comb begin
    halt_cnt_d = halt_cnt_q;
    if (state_q == ST_HALTED) begin
      if (state_d != ST_HALTED)  halt_cnt_d = '0;
      else if (~&halt_cnt_q)     halt_cnt_d = halt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) halt_cnt_q <= '0;
    else          halt_cnt_q <= halt_cnt_d;
  end

  assign halt_cnt = halt_cnt_q;
`endif

endmodule
